ifetch: RTL and testbench

- Instruction fetch stage, directly upstream of the main decoder.
- Maintains the fetch PC and drives a single-outstanding request/acknowledge handshake to instruction memory.
- Buffers returned 16-bit instructions in a small prefetch FIFO.
- Presents the head instruction, its opcode field `op[3:0]`, and its PC to decode. Supports stall from downstream and branch/jump redirect with flush.

---
 rtl/ifetch.sv | 187 ++++++++++++++++++
 tb/tb_ifetch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch : instruction fetch stage feeding the main decoder.
//
// Keeps the fetch PC and runs a single-outstanding req/ack handshake to
// instruction memory. Fetched {pc, instruction} pairs go into a small
// prefetch FIFO, and the head of that FIFO is presented to decode.
// Decode can stall the head in place. A branch/jump redirect flushes the FIFO
// and restarts fetch at a new target.
//
// Parameters
//   n        instruction / word-address width
//   RESET_PC fetch PC loaded on reset
//   DEPTH    prefetch FIFO entries (power of two, >= 2)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   imem_req     fetch request to instruction memory
//   imem_addr    word address of the request (the fetch PC)
//   imem_ack     memory accepts request; imem_rdata valid same cycle
//   imem_rdata   instruction word returned with imem_ack
//   redirect     branch/jump taken: flush and restart fetch
//   redirect_pc  new fetch target, sampled with redirect
//   stall        decode cannot accept the head this cycle
//   valid        instr/op/pc_out hold a real instruction
//   instr        head instruction (NOOP = 0 when empty)
//   op           opcode field instr[n-1:n-4]
//   pc_out       PC of the head instruction
//   pc_plus1     pc_out + 1 (wraps), base for branch targets
// ---------------------------------------------------------------------------
module ifetch #(
  parameter int          n        = 16,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [n-1:0] imem_rdata,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  input  logic         stall,
  output logic         valid,
  output logic [n-1:0] instr,
  output logic [3:0]   op,
  output logic [n-1:0] pc_out,
  output logic [n-1:0] pc_plus1
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [n-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [n-1:0]  instr_mem_q [DEPTH];
  logic [n-1:0]  pc_mem_q    [DEPTH];

  logic req_state;
  logic push;
  logic pop;

  // Request is a pure function of state, but it is forced low while reset is
  // held because the reset state is FETCH; this abandons any pending request.
  assign req_state = (state_q == FETCH);
  assign imem_req  = req_state & ~reset;
  assign imem_addr = fetch_pc_q;

  // A redirect discards any ack arriving in the same cycle and also wins
  // over a pop, so neither push nor pop happens in a redirect cycle.
  assign push = imem_req & imem_ack & ~redirect;
  assign pop  = valid & ~stall & ~redirect;

  // Head presentation: an empty FIFO shows a NOOP at PC 0.
  assign valid    = (count_q != '0);
  assign instr    = valid ? instr_mem_q[rd_ptr_q] : '0;
  assign pc_out   = valid ? pc_mem_q[rd_ptr_q] : '0;
  assign op       = instr[n-1 -: 4];
  assign pc_plus1 = pc_out + n'(1);

  // Next-state logic. FULL is entered only when an ack fills the last slot
  // without a simultaneous pop. Leaving FULL needs a pop, because no push can
  // happen there.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        FETCH: begin
          if (push && !pop && (count_q == CW'(DEPTH - 1))) begin
            state_d = FULL;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = FETCH;
          end
        end
        FLUSH: begin
          state_d = FETCH;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // Fetch PC, FIFO pointers and occupancy. A redirect empties the FIFO and
  // reloads the PC without the increment an ack would otherwise cause.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + n'(1);
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State, PC and FIFO bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= n'(RESET_PC);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage. Returned data is stored as-is, so an X on imem_rdata is
  // carried through to decode, where the assertion below reports it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

`ifndef SYNTHESIS
  // Decode must never be handed an unknown opcode on a valid instruction.
  opKnownWhenValid : assert property (@(posedge clk) disable iff (reset)
    valid |-> !$isunknown(op));
`endif

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch : self-checking bench for ifetch.
// Memory returns rdata = addr | 16'h9000. A vector table covers reset release
// and stall/FULL behaviour. Hand sequences cover redirect, PC wrap and
// asynchronous reset. A scoreboard covers fixed and random memory latency
// with random stalls.
// ---------------------------------------------------------------------------
module tb_ifetch;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imemAck;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirectPc;
  logic        stall;
  logic        valid;
  logic [15:0] instr;
  logic [3:0]  op;
  logic [15:0] pc_out;
  logic [15:0] pc_plus1;

  int testsRun = 0;
  int failures = 0;

  typedef struct packed {
    logic        stall;
    logic        ack;
    logic        expReq;
    logic [15:0] expAddr;
    logic        expValid;
    logic [15:0] expInstr;
    logic [15:0] expPc;
  } vec_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } sb_t;

  vec_t vecs [10];

  ifetch #(.n(16), .RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imemAck),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirectPc),
    .stall       (stall),
    .valid       (valid),
    .instr       (instr),
    .op          (op),
    .pc_out      (pc_out),
    .pc_plus1    (pc_plus1)
  );

  // Memory model: the returned word is derived from the requested address.
  assign imem_rdata = imem_addr | 16'h9000;

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and report it if it differs.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive this cycle's inputs (just after a rising edge), then move to the
  // falling edge where outputs are sampled.
  task automatic applyStimulus(input logic s, input logic a, input logic r,
                               input logic [15:0] rpc);
    stall      = s;
    imemAck    = a;
    redirect   = r;
    redirectPc = rpc;
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkHead(input string tag, input logic expValid,
                           input logic [15:0] expInstr, input logic [15:0] expPc);
    logic [15:0] expOp;
    expOp = {12'h000, expInstr[15:12]};
    checkOutput({tag, "_valid"},    {15'h0, valid},  {15'h0, expValid});
    checkOutput({tag, "_instr"},    instr,           expInstr);
    checkOutput({tag, "_op"},       {12'h000, op},   expOp);
    checkOutput({tag, "_pc_out"},   pc_out,          expPc);
    checkOutput({tag, "_pc_plus1"}, pc_plus1,        expPc + 16'h0001);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req"},  {15'h0, imem_req}, 16'h0000);
    checkOutput({tag, "_addr"}, imem_addr,         16'h0000);
    checkHead(tag, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic doReset();
    reset      = 1'b1;
    stall      = 1'b0;
    imemAck    = 1'b0;
    redirect   = 1'b0;
    redirectPc = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard run starting just after a reset release. The bench keeps its
  // own fetch PC; each accepted ack pushes the expected {pc, instr}, and each
  // consumed head pops one. Occupancy determines expected valid and req.
  task automatic runScoreboard(input string tag, input int cycles,
                               input int fixedLat, input bit randomStall);
    sb_t         sbQ [$];
    sb_t         e;
    logic [15:0] expPc;
    int          waitCnt;
    int          curLat;
    logic        s;
    logic        a;
    expPc   = 16'h0000;
    waitCnt = 0;
    curLat  = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 3));
    for (int c = 0; c < cycles; c++) begin
      s = randomStall ? ($urandom_range(0, 9) < 3) : 1'b0;
      a = imem_req && (waitCnt == curLat - 1);
      applyStimulus(s, a, 1'b0, 16'h0000);
      checkOutput({tag, "_valid"}, {15'h0, valid}, {15'h0, sbQ.size() != 0});
      checkOutput({tag, "_req"}, {15'h0, imem_req}, {15'h0, sbQ.size() < DEPTH});
      if (imem_req) checkOutput({tag, "_addr"}, imem_addr, expPc);
      if (valid && sbQ.size() != 0) begin
        checkOutput({tag, "_instr"}, instr, sbQ[0].instr);
        checkOutput({tag, "_pc_out"}, pc_out, sbQ[0].pc);
      end
      if (valid && !s && sbQ.size() != 0) void'(sbQ.pop_front());
      if (imem_req && a) begin
        e.pc    = expPc;
        e.instr = expPc | 16'h9000;
        sbQ.push_back(e);
        expPc   = expPc + 16'h0001;
        waitCnt = 0;
        curLat  = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 3));
      end else if (imem_req) begin
        waitCnt++;
      end else begin
        waitCnt = 0;
      end
      nextCycle();
    end
  endtask

  initial begin
    // Reset release, 5-cycle stall fills the FIFO, then drain.
    vecs[0] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h9000, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 16'h9000, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 16'h9000, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 16'h9000, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 16'h9000, 16'h0000};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 16'h9000, 16'h0000};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h9001, 16'h0001};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 16'h9002, 16'h0002};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 16'h0000, 16'h0000};

    reset = 1'b1;
    stall = 1'b0;
    imemAck = 1'b0;
    redirect = 1'b0;
    redirectPc = 16'h0000;
    #3;
    checkResetOutputs("rst_hold");
    doReset();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].ack, 1'b0, 16'h0000);
      checkOutput($sformatf("vec%0d_req", i), {15'h0, imem_req}, {15'h0, vecs[i].expReq});
      checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].expAddr);
      checkHead($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expInstr, vecs[i].expPc);
      nextCycle();
    end

    // Redirect in the same cycle as an ack: ack data dropped, FLUSH, restart.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("redir_c0_addr", imem_addr, 16'h0000);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0040);
    checkHead("redir_c1", 1'b1, 16'h9000, 16'h0000);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("redir_flush_req", {15'h0, imem_req}, 16'h0000);
    checkOutput("redir_flush_valid", {15'h0, valid}, 16'h0000);
    checkOutput("redir_flush_addr", imem_addr, 16'h0040);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("redir_fetch_req", {15'h0, imem_req}, 16'h0001);
    checkOutput("redir_fetch_addr", imem_addr, 16'h0040);
    checkOutput("redir_fetch_valid", {15'h0, valid}, 16'h0000);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkHead("redir_first", 1'b1, 16'h9040, 16'h0040);
    checkOutput("redir_next_addr", imem_addr, 16'h0041);
    nextCycle();

    // Fetch PC wrap from FFFF to 0000.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("wrap_flush_addr", imem_addr, 16'hFFFF);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("wrap_req", {15'h0, imem_req}, 16'h0001);
    checkOutput("wrap_addr", imem_addr, 16'hFFFF);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("wrap_next_addr", imem_addr, 16'h0000);
    checkHead("wrap_head", 1'b1, 16'hFFFF, 16'hFFFF);
    nextCycle();

    // Asynchronous reset with the FIFO full, then again mid-request.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    nextCycle();
    checkOutput("full_req", {15'h0, imem_req}, 16'h0000);
    checkHead("full_head", 1'b1, 16'h9000, 16'h0000);
    #1;
    reset = 1'b1;
    #1;
    checkResetOutputs("async_full");
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("restart_req", {15'h0, imem_req}, 16'h0001);
    checkOutput("restart_addr", imem_addr, 16'h0000);
    checkOutput("restart_valid", {15'h0, valid}, 16'h0000);
    nextCycle();
    #1;
    reset = 1'b1;
    #1;
    checkResetOutputs("async_req");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fixed 3-cycle memory latency, then random latency with random stalls.
    doReset();
    runScoreboard("lat3", 40, 3, 1'b0);
    doReset();
    runScoreboard("rand", 300, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
